// File: rtl/axi_req_sequencer_if.sv
// Core-request / AXI-lite-master bundle around axi_req_sequencer.
// The master modport is the side that feeds requests and completions; slave is the sequencer.
interface axi_req_sequencer_if;
    logic        i_req_valid;
    logic        i_req_write;
    logic [31:0] i_req_addr;
    logic [31:0] i_req_wdata;
    logic [3:0]  i_req_strobe;
    logic        i_req_sel;
    logic        o_req_ready;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;
    logic [31:0] o_axi_addr_reg;
    logic [31:0] o_axi_data_reg;
    logic [3:0]  o_axi_strobe_reg;
    logic        o_axi_sel_reg;
    logic [1:0]  o_axi_control_reg;
    logic        i_wr_done;
    logic        i_rd_done;
    logic [31:0] i_rd_data;
    logic        i_resp_err;
    logic        o_busy;
    logic [4:0]  o_fifo_level;

    // Handshake: a request transfers on the rising edge where i_req_valid and o_req_ready are both
    // high; o_rsp_valid is a single-cycle pulse with no back-pressure; i_wr_done/i_rd_done are
    // already-completed AXI handshakes and are only honoured in the matching wait state.
    modport master (
        output i_req_valid, i_req_write, i_req_addr, i_req_wdata, i_req_strobe, i_req_sel,
        output i_wr_done, i_rd_done, i_rd_data, i_resp_err,
        input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
        input  o_axi_addr_reg, o_axi_data_reg, o_axi_strobe_reg, o_axi_sel_reg, o_axi_control_reg,
        input  o_busy, o_fifo_level
    );

    modport slave (
        input  i_req_valid, i_req_write, i_req_addr, i_req_wdata, i_req_strobe, i_req_sel,
        input  i_wr_done, i_rd_done, i_rd_data, i_resp_err,
        output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
        output o_axi_addr_reg, o_axi_data_reg, o_axi_strobe_reg, o_axi_sel_reg, o_axi_control_reg,
        output o_busy, o_fifo_level
    );
endinterface

// File: rtl/axi_req_sequencer.sv
// Queues core load/store requests and runs them one at a time through an AXI-lite master,
// returning one in-order response per request with a per-transaction timeout.
module axi_req_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic               aclk,
    input  logic               areset_n,
    axi_req_sequencer_if.slave bus,
    output logic [2:0]         dbg_state
);
    localparam int         AW       = $clog2(DEPTH);
    localparam logic [4:0] DEPTH_L  = 5'(DEPTH);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT_WR = 3'd2,
        WAIT_RD = 3'd3,
        RESP    = 3'd4
    } state_t;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strobe;
        logic        sel;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        in_entry;
    entry_t        head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [4:0]    level;
    logic [7:0]    tmo_cnt;
    state_t        state;
    logic          cur_write;
    logic          push;
    logic          pop;
    logic          bypass;
    logic          fifo_wr;
    logic          fifo_rd;

    assign in_entry = {bus.i_req_write, bus.i_req_addr, bus.i_req_wdata, bus.i_req_strobe, bus.i_req_sel};

    // An idle sequencer with an empty FIFO takes the incoming request straight to ISSUE,
    // which gives the accept -> ISSUE -> WAIT -> RESP minimum latency of three cycles.
    assign pop     = (state == IDLE) && ((level != 5'd0) || push);
    assign bypass  = pop && (level == 5'd0);
    assign fifo_wr = push && !bypass;
    assign fifo_rd = pop && !bypass;
    assign head    = bypass ? in_entry : mem[rd_ptr];

    assign bus.o_req_ready  = (level < DEPTH_L);
    assign push             = bus.i_req_valid && bus.o_req_ready;
    assign bus.o_fifo_level = level;
    assign bus.o_busy       = (state != IDLE) || (level != 5'd0);
    assign dbg_state        = state;

    always_ff @(posedge aclk) begin
        if (fifo_wr) mem[wr_ptr] <= in_entry;
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state                 <= IDLE;
            wr_ptr                <= '0;
            rd_ptr                <= '0;
            level                 <= '0;
            tmo_cnt               <= '0;
            cur_write             <= 1'b0;
            bus.o_axi_addr_reg    <= '0;
            bus.o_axi_data_reg    <= '0;
            bus.o_axi_strobe_reg  <= '0;
            bus.o_axi_sel_reg     <= 1'b0;
            bus.o_axi_control_reg <= 2'b00;
            bus.o_rsp_valid       <= 1'b0;
            bus.o_rsp_err         <= 1'b0;
            bus.o_rsp_rdata       <= '0;
        end else begin
            if (fifo_wr) wr_ptr <= wr_ptr + AW'(1);
            if (fifo_rd) rd_ptr <= rd_ptr + AW'(1);
            level <= level + 5'(fifo_wr) - 5'(fifo_rd);

            case (state)
                IDLE: begin
                    if (pop) begin
                        cur_write             <= head.write;
                        bus.o_axi_addr_reg    <= head.addr;
                        bus.o_axi_data_reg    <= head.data;
                        bus.o_axi_strobe_reg  <= head.strobe;
                        bus.o_axi_sel_reg     <= head.sel;
                        bus.o_axi_control_reg <= head.write ? 2'b01 : 2'b10;
                        tmo_cnt               <= '0;
                        state                 <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.o_axi_control_reg <= 2'b00;
                    tmo_cnt               <= '0;
                    state                 <= cur_write ? WAIT_WR : WAIT_RD;
                end
                WAIT_WR: begin
                    tmo_cnt <= tmo_cnt + 8'd1;
                    // A completion in the final wait cycle beats the timeout.
                    if (bus.i_wr_done) begin
                        bus.o_rsp_valid <= 1'b1;
                        bus.o_rsp_err   <= bus.i_resp_err;
                        bus.o_rsp_rdata <= '0;
                        state           <= RESP;
                    end else if (tmo_cnt == TMO_LAST) begin
                        bus.o_rsp_valid <= 1'b1;
                        bus.o_rsp_err   <= 1'b1;
                        bus.o_rsp_rdata <= '0;
                        state           <= RESP;
                    end
                end
                WAIT_RD: begin
                    tmo_cnt <= tmo_cnt + 8'd1;
                    if (bus.i_rd_done) begin
                        bus.o_rsp_valid <= 1'b1;
                        bus.o_rsp_err   <= bus.i_resp_err;
                        bus.o_rsp_rdata <= bus.i_resp_err ? 32'd0 : bus.i_rd_data;
                        state           <= RESP;
                    end else if (tmo_cnt == TMO_LAST) begin
                        bus.o_rsp_valid <= 1'b1;
                        bus.o_rsp_err   <= 1'b1;
                        bus.o_rsp_rdata <= '0;
                        state           <= RESP;
                    end
                end
                RESP: begin
                    bus.o_rsp_valid <= 1'b0;
                    bus.o_rsp_err   <= 1'b0;
                    bus.o_rsp_rdata <= '0;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_req_sequencer.sv
// Bench for axi_req_sequencer: directed and random traffic against a transaction timeline model
// (accept / issue / response cycle per request) with an in-order expected-response queue.
module tb_axi_req_sequencer;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 255;
    localparam int MAXT    = 1024;

    logic       aclk = 1'b0;
    logic       areset_n;
    logic [2:0] dbg_state;
    int         cyc = 0;

    axi_req_sequencer_if bus ();

    axi_req_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .aclk      (aclk),
        .areset_n  (areset_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // timeline model: one record per accepted request
    int          acc_c  [MAXT];
    int          iss_c  [MAXT];
    int          rsp_c  [MAXT];
    int          dly_a  [MAXT];
    bit          wr_a   [MAXT];
    logic [31:0] addr_a [MAXT];
    logic [31:0] wdat_a [MAXT];
    logic [3:0]  strb_a [MAXT];
    bit          sel_a  [MAXT];
    bit          err_a  [MAXT];
    logic [31:0] rdat_a [MAXT];
    int          n_tx    = 0;
    int          first_k = 0;
    logic [32:0] exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    bit          nx_write;
    logic [31:0] nx_addr;
    logic [31:0] nx_wdata;
    logic [3:0]  nx_strb;
    bit          nx_sel;
    int          nx_dly;
    bit          nx_err;
    logic [31:0] nx_rdata;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int level_at(input int c);
        int l = 0;
        for (int k = first_k; k < n_tx; k++)
            if (acc_c[k] < c && iss_c[k] > c) l++;
        return l;
    endfunction

    function automatic int active_at(input int c);
        for (int k = first_k; k < n_tx; k++)
            if (iss_c[k] <= c && c <= rsp_c[k]) return k;
        return -1;
    endfunction

    task automatic set_req(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input bit sl, input int dl, input bit e, input logic [31:0] rd);
        nx_write = w; nx_addr = a; nx_wdata = d; nx_strb = s;
        nx_sel = sl; nx_dly = dl; nx_err = e; nx_rdata = rd;
    endtask

    task automatic rand_req();
        int r;
        r = int'($urandom_range(0, 99));
        set_req(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)), (r < 85) ? int'($urandom_range(1, 6)) : int'($urandom_range(7, 20)),
                ($urandom_range(0, 7) == 0), $urandom);
    endtask

    task automatic accept(input int c);
        int  k;
        bit  to;
        logic [31:0] rd;
        k = n_tx;
        acc_c[k] = c; wr_a[k] = nx_write; addr_a[k] = nx_addr; wdat_a[k] = nx_wdata;
        strb_a[k] = nx_strb; sel_a[k] = nx_sel; dly_a[k] = nx_dly; err_a[k] = nx_err; rdat_a[k] = nx_rdata;
        iss_c[k] = c + 1;
        if (k != first_k && rsp_c[k-1] + 2 > iss_c[k]) iss_c[k] = rsp_c[k-1] + 2;
        to = (nx_dly > TIMEOUT);
        rsp_c[k] = iss_c[k] + 1 + (to ? TIMEOUT : nx_dly);
        rd = (to || nx_err || nx_write) ? 32'd0 : nx_rdata;
        exp_q.push_back({to | nx_err, rd});
        n_tx++;
    endtask

    task automatic check_cycle(input int c);
        int lv;
        int k;
        logic [32:0] e;
        lv = level_at(c);
        k  = active_at(c);
        check("req_ready", 64'(bus.o_req_ready), 64'(lv < DEPTH));
        check("fifo_level", 64'(bus.o_fifo_level), 64'(lv));
        check("busy", 64'(bus.o_busy), 64'((k >= 0) || (lv > 0)));
        if (k >= 0 && iss_c[k] == c) check("control", 64'(bus.o_axi_control_reg), wr_a[k] ? 64'd1 : 64'd2);
        else check("control", 64'(bus.o_axi_control_reg), 64'd0);
        if (k >= 0) begin
            check("axi_addr", 64'(bus.o_axi_addr_reg), 64'(addr_a[k]));
            check("axi_data", 64'(bus.o_axi_data_reg), 64'(wdat_a[k]));
            check("axi_strobe", 64'(bus.o_axi_strobe_reg), 64'(strb_a[k]));
            check("axi_sel", 64'(bus.o_axi_sel_reg), 64'(sel_a[k]));
        end
        if (k >= 0 && rsp_c[k] == c) begin
            check("rsp_valid", 64'(bus.o_rsp_valid), 64'd1);
            e = exp_q.pop_front();
            check("rsp_err_rdata", 64'({bus.o_rsp_err, bus.o_rsp_rdata}), 64'(e));
        end else begin
            check("rsp_valid", 64'(bus.o_rsp_valid), 64'd0);
        end
    endtask

    // driver: one clock cycle of request plus modelled AXI completion behaviour
    task automatic step(input bit v);
        int c;
        int k;
        int w;
        @(posedge aclk);
        #1;
        c = cyc;
        bus.i_req_valid = v;
        if (v) begin
            bus.i_req_write = nx_write; bus.i_req_addr = nx_addr; bus.i_req_wdata = nx_wdata;
            bus.i_req_strobe = nx_strb; bus.i_req_sel = nx_sel;
        end else begin
            bus.i_req_write = 1'($urandom_range(0, 1)); bus.i_req_addr = $urandom; bus.i_req_wdata = $urandom;
            bus.i_req_strobe = 4'($urandom_range(0, 15)); bus.i_req_sel = 1'($urandom_range(0, 1));
        end
        bus.i_wr_done  = 1'b0;
        bus.i_rd_done  = 1'b0;
        bus.i_rd_data  = $urandom;
        bus.i_resp_err = 1'($urandom_range(0, 1));
        k = active_at(c);
        if (k >= 0 && c > iss_c[k] && c < rsp_c[k]) begin
            w = c - iss_c[k];
            if (wr_a[k]) begin
                bus.i_rd_done = ($urandom_range(0, 3) == 0);
                if (dly_a[k] <= TIMEOUT && w == dly_a[k]) begin
                    bus.i_wr_done  = 1'b1;
                    bus.i_resp_err = err_a[k];
                end
            end else begin
                bus.i_wr_done = ($urandom_range(0, 3) == 0);
                if (dly_a[k] <= TIMEOUT && w == dly_a[k]) begin
                    bus.i_rd_done  = 1'b1;
                    bus.i_rd_data  = rdat_a[k];
                    bus.i_resp_err = err_a[k];
                end
            end
        end else begin
            bus.i_wr_done = ($urandom_range(0, 3) == 0);
            bus.i_rd_done = ($urandom_range(0, 3) == 0);
        end
        @(negedge aclk);
        check_cycle(c);
        if (v && level_at(c) < DEPTH) accept(c);
    endtask

    task automatic drain();
        int guard = 0;
        while (n_tx > first_k && cyc <= rsp_c[n_tx-1] + 1 && guard < 3000) begin
            step(1'b0);
            guard++;
        end
        if (guard >= 3000) check("drain_budget", 64'(guard), 64'd0);
        step(1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 64'(bus.o_req_ready), 64'd1);
        check({tag, "_level"}, 64'(bus.o_fifo_level), 64'd0);
        check({tag, "_rsp_valid"}, 64'(bus.o_rsp_valid), 64'd0);
        check({tag, "_rsp"}, 64'({bus.o_rsp_err, bus.o_rsp_rdata}), 64'd0);
        check({tag, "_axi_addr"}, 64'(bus.o_axi_addr_reg), 64'd0);
        check({tag, "_axi_data"}, 64'(bus.o_axi_data_reg), 64'd0);
        check({tag, "_axi_strb_sel"}, 64'({bus.o_axi_strobe_reg, bus.o_axi_sel_reg}), 64'd0);
        check({tag, "_control"}, 64'(bus.o_axi_control_reg), 64'd0);
        check({tag, "_busy"}, 64'(bus.o_busy), 64'd0);
        check({tag, "_state"}, 64'(dbg_state), 64'd0);
    endtask

    initial begin
        bus.i_req_valid = 1'b0; bus.i_req_write = 1'b0; bus.i_req_addr = '0; bus.i_req_wdata = '0;
        bus.i_req_strobe = '0; bus.i_req_sel = 1'b0; bus.i_wr_done = 1'b0; bus.i_rd_done = 1'b0;
        bus.i_rd_data = '0; bus.i_resp_err = 1'b0;
        areset_n = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        check_reset_outputs("reset");
        @(negedge aclk);
        areset_n = 1'b1;

        // store, completion in first wait cycle
        set_req(1'b1, 32'h1000_0004, 32'h0000_0055, 4'hF, 1'b0, 1, 1'b0, 32'h0); step(1'b1); drain();
        // load returning data
        set_req(1'b0, 32'h1000_0008, 32'h0, 4'h0, 1'b1, 1, 1'b0, 32'hA5A5_1234); step(1'b1); drain();
        // load with slave error, store with slave error
        set_req(1'b0, 32'h2000_0010, 32'h0, 4'h0, 1'b0, 3, 1'b1, 32'hDEAD_BEEF); step(1'b1); drain();
        set_req(1'b1, 32'h2000_0014, 32'h1234_5678, 4'h3, 1'b1, 2, 1'b1, 32'h0); step(1'b1); drain();
        // completion on the last cycle before timeout
        set_req(1'b0, 32'h3000_0000, 32'h0, 4'h0, 1'b0, TIMEOUT, 1'b0, 32'h0BAD_F00D); step(1'b1); drain();
        // timeout, with a second request queued behind it
        set_req(1'b1, 32'h3000_0004, 32'hCAFE_0001, 4'hC, 1'b0, TIMEOUT + 1, 1'b0, 32'h0); step(1'b1);
        set_req(1'b0, 32'h3000_0008, 32'h0, 4'h0, 1'b1, 2, 1'b0, 32'h7777_8888); step(1'b1);
        drain();
        // fill the FIFO: five accepted, sixth refused
        for (int i = 0; i < 6; i++) begin
            rand_req();
            nx_write = 1'b1;
            nx_dly = 10;
            step(1'b1);
        end
        drain();

        // random traffic
        for (int i = 0; i < 500; i++) begin
            rand_req();
            step(($urandom_range(0, 2) != 0));
        end
        drain();

        // reset while a load waits with two requests queued
        set_req(1'b0, 32'h4000_0000, 32'h0, 4'h0, 1'b0, TIMEOUT + 1, 1'b0, 32'h1111_2222); step(1'b1);
        set_req(1'b1, 32'h4000_0004, 32'h5, 4'hF, 1'b0, 1, 1'b0, 32'h0); step(1'b1);
        set_req(1'b1, 32'h4000_0008, 32'h6, 4'hF, 1'b0, 1, 1'b0, 32'h0); step(1'b1);
        step(1'b0);
        #2;
        areset_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        first_k = n_tx;
        exp_q.delete();
        @(negedge aclk);
        @(negedge aclk);
        areset_n = 1'b1;
        for (int i = 0; i < 20; i++) step(1'b0);

        // normal operation after reset
        set_req(1'b1, 32'h5000_0000, 32'h9, 4'h1, 1'b1, 2, 1'b0, 32'h0); step(1'b1); drain();
        check("exp_q_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
